shift_reg: RTL and testbench
============================

// Module: shift_reg
// PURPOSE
//  Parametrised successor to the plain D register. Adds parallel load, synchronous
//  clear and serial shift in/out, with a shift counter and a sticky done flag.
//  Serves as the datapath core of the UART TX (PISO) and RX (SIPO) paths.
//  Single clock domain.
// PARAMETERS
//  numBit    10          register width; frame = start + 8 data + stop; must be >= 2
//  LSB_FIRST 1           1: shift toward bit 0, ser_out = q[0], ser_in enters q[numBit-1]
//                        0: shift toward MSB, ser_out = q[numBit-1], ser_in enters q[0]
//  RST_VAL   {numBit{1'b1}}  value on reset/clear; all ones = idle-high line
// PORTS
//  clk      in   1                   clock, rising edge
//  RSTn     in   1                   asynchronous, active-low reset
//  clr      in   1                   synchronous clear to RST_VAL
//  load     in   1                   parallel load of d
//  d        in   numBit              parallel load data
//  shift    in   1                   shift one bit per cycle while high
//  ser_in   in   1                   serial input bit
//  q        out  numBit              register contents
//  ser_out  out  1                   serial output bit (combinational from q)
//  cnt      out  $clog2(numBit+1)    shifts since last load/clr; saturates at numBit
//  done     out  1                   sticky: numBit shifts completed
// BEHAVIOUR
//  - Reset (RSTn=0) takes effect immediately, independent of clk:
//    q=RST_VAL, cnt=0, done=0, ser_out=RST_VAL bit selected per LSB_FIRST.
//  - Control priority per rising edge: clr > load > shift > hold.
//  - clr:   q<=RST_VAL, cnt<=0, done<=0.
//  - load:  q<=d, cnt<=0, done<=0. Any shift in the same cycle is ignored.
//  - shift, LSB_FIRST=1: q <= {ser_in, q[numBit-1:1]}
//  - shift, LSB_FIRST=0: q <= {q[numBit-2:0], ser_in}
//  - On shift, cnt increments while cnt < numBit.
//  - done<=1 on the shift that moves cnt from numBit-1 to numBit.
//  - After done: further shifts still move data; cnt holds at numBit; done stays 1
//    until the next load, clr or reset.
//  - Hold (no control asserted): q, cnt and done keep their values.
//  - Latency: q, cnt and done update 1 cycle after the control is sampled.
//    ser_out follows q in the same cycle, with no extra register.
//  - Reset during a shift sequence aborts it: state returns to reset values and
//    the next load starts cleanly.
//  - cnt arithmetic is unsigned. cnt never exceeds numBit and never wraps.
// TESTING (numBit=10, RST_VAL=10'h3FF, LSB_FIRST=1 unless stated)
//  1 Async reset: drop RSTn between clock edges -> immediately q=3FF, ser_out=1,
//    cnt=0, done=0.
//  2 PISO: load d=10'h2A4, then 10 shifts with ser_in=1 -> ser_out sequence
//    0,0,1,0,0,1,0,1,0,1. After the 10th shift: cnt=10, done=1, q=3FF.
//  3 SIPO: clr, then shift in the bits of 10'h155 LSB first -> q=155, done=1
//    on the 10th shift edge, not before.
//  4 Priority: load(d=0AA)+shift in one cycle -> q=0AA, cnt=0.
//    clr+load in one cycle -> q=3FF.
//  5 Saturation/hold: 13 shifts after a load -> cnt=10, done=1.
//    Then shift=0 for 5 cycles -> q unchanged.
//  6 Reset mid-op: assert RSTn=0 after 4 shifts -> cnt=0, done=0, q=3FF.
//    A subsequent load of 2A4 plus 10 shifts completes normally.
//    Separately, a LSB_FIRST=0 instance loaded with 2A4 gives first ser_out=1 (bit 9).

Source files
------------

// File: rtl/shift_reg.sv
// shift_reg: parametrised shift register with parallel load, synchronous clear,
// serial in/out, saturating shift counter and sticky done flag. Datapath core
// for UART TX (PISO) and RX (SIPO).
//
// Ports:
//   clk      in   rising-edge clock
//   RSTn     in   asynchronous active-low reset
//   clr      in   synchronous clear to RST_VAL (highest priority)
//   load     in   parallel load of d (beats shift)
//   d        in   parallel load data [numBit-1:0]
//   shift    in   shift one bit per cycle while high
//   ser_in   in   serial input bit
//   q        out  register contents (registered)
//   ser_out  out  serial output bit, combinational from q
//   cnt      out  shifts since last load/clr, saturates at numBit (registered)
//   done     out  sticky, set when numBit shifts have completed (registered)
//
// numBit must be at least 2.
module shift_reg #(
    parameter int unsigned         numBit    = 10,
    parameter bit                  LSB_FIRST = 1'b1,
    parameter logic [numBit-1:0]   RST_VAL   = {numBit{1'b1}}
) (
    input  logic                         clk,
    input  logic                         RSTn,
    input  logic                         clr,
    input  logic                         load,
    input  logic [numBit-1:0]            d,
    input  logic                         shift,
    input  logic                         ser_in,
    output logic [numBit-1:0]            q,
    output logic                         ser_out,
    output logic [$clog2(numBit+1)-1:0]  cnt,
    output logic                         done
);

    localparam int unsigned   CNT_W   = $clog2(numBit + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(numBit);

    logic [numBit-1:0] q_q,    q_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              done_q, done_d;

    // Next-state: clr > load > shift > hold.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (clr) begin
            q_d    = RST_VAL;
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (load) begin
            q_d    = d;
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (shift) begin
            if (LSB_FIRST) begin
                q_d = {ser_in, q_q[numBit-1:1]};
            end else begin
                q_d = {q_q[numBit-2:0], ser_in};
            end
            // Counter saturates at numBit; done is set on the final step and
            // then held until the next load/clr/reset.
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_MAX - CNT_W'(1)) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            q_q    <= RST_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q       = q_q;
    assign cnt     = cnt_q;
    assign done    = done_q;
    // Line-side bit, no extra register so it tracks q in the same cycle.
    assign ser_out = LSB_FIRST ? q_q[0] : q_q[numBit-1];

endmodule

// File: tb/tb_shift_reg.sv
// tb_shift_reg: directed, table-driven bench for shift_reg (numBit=10,
// RST_VAL=3FF). Main instance is LSB_FIRST=1; a second LSB_FIRST=0 instance
// shares the inputs and is checked at a few points.
module tb_shift_reg;

    typedef struct {
        logic       clr;
        logic       load;
        logic       shift;
        logic       ser_in;
        logic [9:0] d;
        logic [9:0] exp_q;
        logic [3:0] exp_cnt;
        logic       exp_done;
        logic       exp_ser;
    } vec_t;

    logic       clk = 1'b0;
    logic       RSTn;
    logic       clr, load, shift, ser_in;
    logic [9:0] d;
    logic [9:0] q,   q0;
    logic       ser_out, ser_out0;
    logic [3:0] cnt, cnt0;
    logic       done, done0;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    shift_reg #(.numBit(10), .LSB_FIRST(1'b1), .RST_VAL(10'h3FF)) dut (
        .clk(clk), .RSTn(RSTn), .clr(clr), .load(load), .d(d), .shift(shift),
        .ser_in(ser_in), .q(q), .ser_out(ser_out), .cnt(cnt), .done(done)
    );

    shift_reg #(.numBit(10), .LSB_FIRST(1'b0), .RST_VAL(10'h3FF)) dut0 (
        .clk(clk), .RSTn(RSTn), .clr(clr), .load(load), .d(d), .shift(shift),
        .ser_in(ser_in), .q(q0), .ser_out(ser_out0), .cnt(cnt0), .done(done0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [9:0] eq,
                               input logic [3:0] ec, input logic ed, input logic es);
        check({tag, " q"},       32'(q),       32'(eq));
        check({tag, " cnt"},     32'(cnt),     32'(ec));
        check({tag, " done"},    32'(done),    32'(ed));
        check({tag, " ser_out"}, 32'(ser_out), 32'(es));
    endtask

    task automatic drive(input logic c, input logic l, input logic s,
                         input logic si, input logic [9:0] dd);
        clr = c; load = l; shift = s; ser_in = si; d = dd;
    endtask

    // Drive, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic c, input logic l, input logic s,
                        input logic si, input logic [9:0] dd);
        drive(c, l, s, si, dd);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic l, input logic s, input logic si,
                       input logic [9:0] dd, input logic [9:0] eq,
                       input logic [3:0] ec, input logic ed, input logic es);
        vec_t v;
        v.clr = c; v.load = l; v.shift = s; v.ser_in = si; v.d = dd;
        v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed; v.exp_ser = es;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // PISO: load 2A4 then 10 shifts with ser_in=1.
        add(0, 1, 0, 0, 10'h2A4, 10'h2A4, 4'd0,  0, 0);
        add(0, 0, 1, 1, 10'h000, 10'h352, 4'd1,  0, 0);
        add(0, 0, 1, 1, 10'h000, 10'h3A9, 4'd2,  0, 1);
        add(0, 0, 0, 1, 10'h000, 10'h3A9, 4'd2,  0, 1); // hold mid-sequence
        add(0, 0, 1, 1, 10'h000, 10'h3D4, 4'd3,  0, 0);
        add(0, 0, 1, 1, 10'h000, 10'h3EA, 4'd4,  0, 0);
        add(0, 0, 1, 1, 10'h000, 10'h3F5, 4'd5,  0, 1);
        add(0, 0, 1, 1, 10'h000, 10'h3FA, 4'd6,  0, 0);
        add(0, 0, 1, 1, 10'h000, 10'h3FD, 4'd7,  0, 1);
        add(0, 0, 1, 1, 10'h000, 10'h3FE, 4'd8,  0, 0);
        add(0, 0, 1, 1, 10'h000, 10'h3FF, 4'd9,  0, 1);
        add(0, 0, 1, 1, 10'h000, 10'h3FF, 4'd10, 1, 1);
        // SIPO: clr, then shift in 155 LSB first.
        add(1, 0, 0, 0, 10'h000, 10'h3FF, 4'd0,  0, 1);
        add(0, 0, 1, 1, 10'h000, 10'h3FF, 4'd1,  0, 1);
        add(0, 0, 1, 0, 10'h000, 10'h1FF, 4'd2,  0, 1);
        add(0, 0, 1, 1, 10'h000, 10'h2FF, 4'd3,  0, 1);
        add(0, 0, 1, 0, 10'h000, 10'h17F, 4'd4,  0, 1);
        add(0, 0, 1, 1, 10'h000, 10'h2BF, 4'd5,  0, 1);
        add(0, 0, 1, 0, 10'h000, 10'h15F, 4'd6,  0, 1);
        add(0, 0, 1, 1, 10'h000, 10'h2AF, 4'd7,  0, 1);
        add(0, 0, 1, 0, 10'h000, 10'h157, 4'd8,  0, 1);
        add(0, 0, 1, 1, 10'h000, 10'h2AB, 4'd9,  0, 1);
        add(0, 0, 1, 0, 10'h000, 10'h155, 4'd10, 1, 1);
        // Priority: load beats shift, clr beats load.
        add(0, 1, 1, 1, 10'h0AA, 10'h0AA, 4'd0,  0, 0);
        add(0, 0, 1, 1, 10'h000, 10'h255, 4'd1,  0, 1);
        add(1, 1, 1, 0, 10'h123, 10'h3FF, 4'd0,  0, 1);

        drive(0, 0, 0, 0, 10'h000);
        RSTn = 1'b0;
        #12;
        check_state("reset", 10'h3FF, 4'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1 RSTn = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].load, vecs[i].shift, vecs[i].ser_in, vecs[i].d);
            check_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt,
                        vecs[i].exp_done, vecs[i].exp_ser);
        end

        // MSB-first instance: load 2A4 shows bit 9 first, then shifts toward MSB.
        step(0, 1, 0, 0, 10'h2A4);
        check("msb load ser_out", 32'(ser_out0), 32'(1'b1));
        check("msb load q",       32'(q0),       32'(10'h2A4));
        step(0, 0, 1, 1, 10'h000);
        check("msb shift q",       32'(q0),       32'(10'h149));
        check("msb shift ser_out", 32'(ser_out0), 32'(1'b0));
        check("msb shift cnt",     32'(cnt0),     32'(4'd1));

        // Saturation: 13 shifts of zeros after a load, then 5 hold cycles.
        step(0, 1, 0, 0, 10'h2A4);
        for (int k = 1; k <= 13; k++) begin
            step(0, 0, 1, 0, 10'h000);
            check($sformatf("sat cnt%0d", k),  32'(cnt),  (k < 10) ? 32'(k) : 32'd10);
            check($sformatf("sat done%0d", k), 32'(done), (k < 10) ? 32'd0 : 32'd1);
        end
        check("sat q", 32'(q), 32'(10'h000));
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, 10'h3FF);
            check_state($sformatf("hold%0d", k), 10'h000, 4'd10, 1'b1, 1'b0);
        end

        // Reset mid-operation, asserted between clock edges.
        step(0, 1, 0, 0, 10'h2A4);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 1, 10'h000);
        check("pre-rst cnt", 32'(cnt), 32'd4);
        #2 RSTn = 1'b0;
        #1;
        check_state("async rst", 10'h3FF, 4'd0, 1'b0, 1'b1);
        check("async rst msb ser_out", 32'(ser_out0), 32'(1'b1));
        drive(0, 0, 0, 0, 10'h000);
        @(posedge clk);
        #1 RSTn = 1'b1;
        step(0, 1, 0, 0, 10'h2A4);
        check_state("post-rst load", 10'h2A4, 4'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 1, 1, 10'h000);
            check($sformatf("post-rst done%0d", k), 32'(done), (k == 10) ? 32'd1 : 32'd0);
        end
        check_state("post-rst end", 10'h3FF, 4'd10, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
